// File: rtl/serial_adder_if.sv
// Operand/result bundle of the serial adder.
// The requester drives start and the operands. The adder returns busy,
// the done pulse and the held result.

interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder_using_half_adder.sv
// One-bit full adder cell built from two half adders.
// The serial adder pushes one operand bit pair plus the running carry
// through this cell on every RUN cycle.

module half_adder (
  input  logic A,
  input  logic B,
  output logic sum,
  output logic carry
);

  // Sum is the XOR of the inputs, and carry is their AND.
  always_comb begin
    sum   = A ^ B;
    carry = A & B;
  end

endmodule

module full_adder_using_half_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic sum,
  output logic cout
);

  logic w_partSum;
  logic w_partCarry;
  logic w_finalCarry;

  half_adder uFirstHalf (
    .A     (A),
    .B     (B),
    .sum   (w_partSum),
    .carry (w_partCarry)
  );

  half_adder uSecondHalf (
    .A     (w_partSum),
    .B     (Cin),
    .sum   (sum),
    .carry (w_finalCarry)
  );

  // A carry out of either half adder is a carry out of the whole cell.
  always_comb begin
    cout = w_partCarry | w_finalCarry;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. The operands are captured on start and then
// added LSB first, one bit per clock, through a single full adder cell with
// a registered carry. The parallel sum and carry-out are published together
// with a one-cycle done pulse.

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_nextState;
  logic [WIDTH-1:0] r_aSr;
  logic [WIDTH-1:0] r_bSr;
  logic [WIDTH-1:0] r_sumSr;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_faSum;
  logic             w_faCout;
  logic [WIDTH-1:0] w_sumNext;
  logic             w_lastBit;

  full_adder_using_half_adder uBitAdder (
    .A    (r_aSr[0]),
    .B    (r_bSr[0]),
    .Cin  (r_carry),
    .sum  (w_faSum),
    .cout (w_faCout)
  );

  // The new sum bit enters at the MSB. After WIDTH shifts, bit 0 of the
  // result has reached the LSB. The shift also covers WIDTH == 1.
  always_comb begin
    w_sumNext = WIDTH'({w_faSum, r_sumSr} >> 1);
    w_lastBit = (r_count == LAST_BIT);
  end

  // State register. Reset is asynchronous so an operation in flight is
  // dropped at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Start only matters in IDLE, and DONE always lasts
  // exactly one cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = RUN;
      RUN:     if (w_lastBit) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Status and result outputs. busy and done are decoded directly from the
  // state register. sum and cout come from the held result registers.
  always_comb begin
    bus.busy = (r_state == RUN);
    bus.done = (r_state == DONE);
    bus.sum  = r_sum;
    bus.cout = r_cout;
  end

  // Datapath. Operands are loaded on an accepted start and shifted during
  // RUN. The result registers change only on the edge that finishes the
  // last bit, so the previous result stays visible for the whole operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aSr   <= '0;
      r_bSr   <= '0;
      r_sumSr <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_aSr   <= bus.a;
            r_bSr   <= bus.b;
            r_carry <= bus.cin;
            r_count <= '0;
            r_sumSr <= '0;
          end
        end
        RUN: begin
          r_sumSr <= w_sumNext;
          r_carry <= w_faCout;
          r_aSr   <= r_aSr >> 1;
          r_bSr   <= r_bSr >> 1;
          r_count <= r_count + 1'b1;
          if (w_lastBit) begin
            r_sum  <= w_sumNext;
            r_cout <= w_faCout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder. An 8-bit instance covers reset, carry
// ripple, busy protection, abort and back-to-back cases. A 2-bit instance
// is swept over every operand combination.

module tb_serial_adder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents operands with start for one cycle. Returns at the first
  // negedge after the accepting edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic cin);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  // Waits, with a bound, until done is seen, counting the busy cycles seen
  // on the way.
  task automatic waitDone8(output int busyCycles, output bit seen);
    busyCycles = 0;
    seen       = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus8.done) begin
        seen = 1'b1;
        break;
      end
      if (bus8.busy) busyCycles++;
      @(negedge clk);
    end
  endtask

  task automatic runOp8(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input logic cin,
                        input logic [7:0] expSum, input logic expCout);
    int busyCycles;
    bit seen;
    applyStimulus(a, b, cin);
    waitDone8(busyCycles, seen);
    checkOutput({tag, "_done"}, 32'(seen), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busyCycles), 32'd8);
    checkOutput({tag, "_sum"}, 32'(bus8.sum), 32'(expSum));
    checkOutput({tag, "_cout"}, 32'(bus8.cout), 32'(expCout));
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, 32'(bus8.done), 32'd0);
  endtask

  initial begin
    int busyCycles;
    bit seen;
    int badCount;
    int cyc;
    int firstDone;
    int secondDone;
    int secondBusy;
    logic [7:0] s1;
    logic [7:0] s2;
    logic c1;
    logic c2;
    int lat;
    logic [2:0] expTotal;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(bus8.busy), 32'd0);
    checkOutput("rst_done", 32'(bus8.done), 32'd0);
    checkOutput("rst_sum", 32'(bus8.sum), 32'd0);
    checkOutput("rst_cout", 32'(bus8.cout), 32'd0);
    rst = 1'b0;

    runOp8("op3C42", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);

    // Asynchronous reset in the middle of a cycle clears the outputs at once.
    #2 rst = 1'b1;
    #1;
    checkOutput("async_sum", 32'(bus8.sum), 32'd0);
    checkOutput("async_cout", 32'(bus8.cout), 32'd0);
    checkOutput("async_busy", 32'(bus8.busy), 32'd0);
    checkOutput("async_done", 32'(bus8.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runOp8("opZero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    runOp8("opFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    runOp8("opA55A", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

    // Busy protection: a start pulse and new operands in the 4th RUN cycle.
    applyStimulus(8'h10, 8'h20, 1'b0);
    repeat (3) @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'h01;
    bus8.b     = 8'h01;
    @(negedge clk);
    bus8.start = 1'b0;
    waitDone8(busyCycles, seen);
    checkOutput("prot_done", 32'(seen), 32'd1);
    checkOutput("prot_busyLeft", 32'(busyCycles), 32'd4);
    checkOutput("prot_sum", 32'(bus8.sum), 32'h30);
    checkOutput("prot_cout", 32'(bus8.cout), 32'd0);
    badCount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) badCount++;
    end
    checkOutput("prot_noSecondOp", 32'(badCount), 32'd0);

    // Reset in the 5th RUN cycle aborts the operation with no done pulse.
    applyStimulus(8'h55, 8'h11, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_sum", 32'(bus8.sum), 32'd0);
    checkOutput("abort_cout", 32'(bus8.cout), 32'd0);
    checkOutput("abort_busy", 32'(bus8.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    badCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done || bus8.busy || bus8.sum != 8'h00) badCount++;
    end
    checkOutput("abort_quiet", 32'(badCount), 32'd0);

    // Back-to-back: start held high across two operations.
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'h7F;
    bus8.b     = 8'h01;
    bus8.cin   = 1'b0;
    cyc = 0; firstDone = -1; secondDone = -1; secondBusy = 0; badCount = 0;
    s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
    for (int i = 0; i < 40 && secondDone < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (bus8.done) begin
        if (firstDone < 0) begin
          firstDone = cyc;
          s1 = bus8.sum;
          c1 = bus8.cout;
          bus8.a = 8'h80;
          bus8.b = 8'h80;
        end else begin
          secondDone = cyc;
          s2 = bus8.sum;
          c2 = bus8.cout;
          bus8.start = 1'b0;
        end
      end else if (firstDone >= 0 && bus8.busy) begin
        secondBusy++;
        if (bus8.sum !== 8'h80) badCount++;
      end
    end
    bus8.start = 1'b0;
    checkOutput("b2b_spacing", 32'(secondDone - firstDone), 32'd10);
    checkOutput("b2b_sum1", 32'(s1), 32'h80);
    checkOutput("b2b_cout1", 32'(c1), 32'd0);
    checkOutput("b2b_sum2", 32'(s2), 32'h00);
    checkOutput("b2b_cout2", 32'(c2), 32'd1);
    checkOutput("b2b_runCycles", 32'(secondBusy), 32'd8);
    checkOutput("b2b_sumHeld", 32'(badCount), 32'd0);

    // Exhaustive sweep of the 2-bit instance.
    @(negedge clk);
    for (int av = 0; av < 4; av++) begin
      for (int bv = 0; bv < 4; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          bus2.start = 1'b1;
          bus2.a     = 2'(av);
          bus2.b     = 2'(bv);
          bus2.cin   = 1'(cv);
          @(negedge clk);
          bus2.start = 1'b0;
          lat = 0;
          while (!bus2.done && lat < 10) begin
            @(negedge clk);
            lat++;
          end
          expTotal = 3'(av + bv + cv);
          checkOutput($sformatf("w2_lat_%0d_%0d_%0d", av, bv, cv), 32'(lat), 32'd2);
          checkOutput($sformatf("w2_res_%0d_%0d_%0d", av, bv, cv),
                      32'({bus2.cout, bus2.sum}), 32'(expTotal));
          @(negedge clk);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
